// File: rtl/subband_serializer.sv
// rtl/subband_serializer.sv - rounds/saturates a captured filterbank frame and streams it out one channel per beat
// Double-buffered: ACTIVE bank drains while one further frame may wait in PENDING.
module subband_serializer #(
  parameter int NCH   = 16,
  parameter int IN_W  = 35,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  frame_strobe,
  input  logic [NCH*IN_W-1:0]   ch_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic [3:0]            out_ch,
  output logic                  out_last,
  output logic                  out_sat,
  output logic                  overrun,
  output logic [7:0]            drop_cnt,
  output logic                  busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MINV = -MAXV - (IN_W+1)'(1);

  state_t state, state_nxt;
  logic [3:0] ch;
  logic       pending_full;

  logic [OUT_W-1:0] act_data  [NCH];
  logic [OUT_W-1:0] pend_data [NCH];
  logic [OUT_W-1:0] cap_data  [NCH];
  logic [NCH-1:0]   act_sat, pend_sat, cap_sat;

  logic hs, final_hs;
  logic load_act_cap, load_act_pend, load_pend_cap, drop;

  // One extra bit of headroom so adding the rounding constant cannot overflow.
  for (genvar k = 0; k < NCH; k++) begin : g_conv
    logic signed [IN_W-1:0] x;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   y;
    assign x   = ch_in[k*IN_W +: IN_W];
    assign sum = {x[IN_W-1], x} + RND;
    assign y   = sum >>> SHIFT;
    always_comb begin
      cap_sat[k] = 1'b0;
      if (y > MAXV) begin
        cap_data[k] = MAXV[OUT_W-1:0];
        cap_sat[k]  = 1'b1;
      end else if (y < MINV) begin
        cap_data[k] = MINV[OUT_W-1:0];
        cap_sat[k]  = 1'b1;
      end else begin
        cap_data[k] = y[OUT_W-1:0];
      end
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = out_valid ? act_data[ch] : '0;
  assign out_sat   = out_valid & act_sat[ch];
  assign out_ch    = out_valid ? ch : 4'd0;
  assign out_last  = out_valid & (ch == 4'(NCH-1));

  assign hs       = out_valid & out_ready;
  assign final_hs = hs & (ch == 4'(NCH-1));

  always_comb begin
    load_act_cap  = frame_strobe & ((state == IDLE) | (final_hs & ~pending_full));
    load_act_pend = final_hs & pending_full;
    load_pend_cap = frame_strobe & (state == SEND) &
                    ((final_hs & pending_full) | (~final_hs & ~pending_full));
    drop          = frame_strobe & (state == SEND) & ~final_hs & pending_full;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (frame_strobe) state_nxt = SEND;
      SEND: if (final_hs && !pending_full && !frame_strobe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else if (clk_enable) state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch           <= 4'd0;
      pending_full <= 1'b0;
      overrun      <= 1'b0;
      drop_cnt     <= 8'd0;
    end else if (clk_enable) begin
      if (load_act_cap || load_act_pend || final_hs) ch <= 4'd0;
      else if (hs) ch <= ch + 4'd1;

      if (load_pend_cap) pending_full <= 1'b1;
      else if (load_act_pend) pending_full <= 1'b0;

      if (drop) begin
        overrun <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Bank contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clock) begin
    if (clk_enable) begin
      for (int k = 0; k < NCH; k++) begin
        if (load_act_cap) begin
          act_data[k] <= cap_data[k];
          act_sat[k]  <= cap_sat[k];
        end else if (load_act_pend) begin
          act_data[k] <= pend_data[k];
          act_sat[k]  <= pend_sat[k];
        end
        if (load_pend_cap) begin
          pend_data[k] <= cap_data[k];
          pend_sat[k]  <= cap_sat[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_subband_serializer.sv
// tb/tb_subband_serializer.sv - scoreboard bench: driver models frame acceptance, monitor checks every beat
module tb_subband_serializer;

  logic          clock = 1'b0;
  logic          reset;
  logic          clk_enable;
  logic          frame_strobe;
  logic [559:0]  ch_in;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [3:0]    out_ch;
  logic          out_last;
  logic          out_sat;
  logic          overrun;
  logic [7:0]    drop_cnt;
  logic          busy;

  subband_serializer dut (
    .clock(clock), .reset(reset), .clk_enable(clk_enable), .frame_strobe(frame_strobe),
    .ch_in(ch_in), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .out_sat(out_sat), .overrun(overrun),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  c;
    logic        l;
    logic        s;
  } beat_t;

  beat_t              q[$];
  int                 n_pass = 0;
  int                 n_chk = 0;
  int                 exp_drops = 0;
  logic signed [34:0] cur [16];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Round half up by floor division, then clamp to 16-bit signed range.
  function automatic beat_t ref_beat(input longint x, input int k);
    beat_t  b;
    longint v, y;
    v = x + 32768;
    if (v >= 0) y = v / 65536;
    else        y = -((-v + 65535) / 65536);
    b.s = 1'b0;
    if (y > 32767)       begin y = 32767;  b.s = 1'b1; end
    else if (y < -32768) begin y = -32768; b.s = 1'b1; end
    b.d = 16'(y);
    b.c = 4'(k);
    b.l = (k == 15);
    return b;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      check("out_valid", out_valid, q.size() != 0);
      check("busy", busy, q.size() != 0);
      check("drop_cnt", drop_cnt, exp_drops);
      check("overrun", overrun, exp_drops != 0);
      if (out_valid && q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_ch", out_ch, q[0].c);
        check("out_last", out_last, q[0].l);
        check("out_sat", out_sat, q[0].s);
        if (out_ready && clk_enable) void'(q.pop_front());
      end
    end
  end

  // A frame is accepted iff the beats still owed after this tick's handshake fit in one bank.
  task automatic step(input bit stb, input bit rdy, input bit en);
    int sz;
    bit hs, acc, drp;
    frame_strobe = stb;
    out_ready    = rdy;
    clk_enable   = en;
    for (int k = 0; k < 16; k++) ch_in[k*35 +: 35] = cur[k];
    sz  = q.size();
    hs  = rdy && en && (sz > 0);
    acc = stb && en && ((sz - int'(hs)) <= 16);
    drp = stb && en && !acc;
    @(posedge clock);
    #1;
    if (acc) for (int k = 0; k < 16; k++) q.push_back(ref_beat(longint'(cur[k]), k));
    if (drp && exp_drops < 255) exp_drops++;
    #1;
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 16; k++) cur[k] = '0;
  endtask

  task automatic fill_random();
    logic [63:0] r;
    longint t;
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: begin r = {$urandom(), $urandom()}; t = longint'($signed(r[34:0])); end
        1: t = longint'($urandom_range(0, 2097151)) - 1048576;
        2: t = (longint'($urandom_range(0, 200)) - 100) * 65536 + 32768 + longint'($urandom_range(0, 2)) - 1;
        default: begin
          t = longint'(32767) * 65536 - 65536 + longint'($urandom_range(0, 196608));
          if ($urandom_range(0, 1) == 1) t = -t;
        end
      endcase
      cur[k] = t[34:0];
    end
  endtask

  task automatic drain(input int max_steps);
    for (int i = 0; i < max_steps && q.size() > 0; i++) step(0, 1, 1);
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b0; frame_strobe = 1'b0; out_ready = 1'b0;
    ch_in = '0;
    fill_zero();
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    step(0, 1, 1);

    // Basic rounding frame
    fill_zero();
    cur[0] = 35'sd98304;
    cur[1] = -35'sd98304;
    step(1, 1, 1);
    check("latency_valid", out_valid, 1);
    drain(20);

    // Saturation extremes and largest in-range value
    fill_zero();
    cur[0] = 35'h3_FFFF_FFFF;
    cur[1] = 35'h4_0000_0000;
    cur[2] = 35'(longint'(32767) << 16);
    step(1, 1, 1);
    drain(20);

    // Backpressure then enable freeze
    fill_random();
    step(1, 1, 1);
    repeat (10) step(0, 0, 1);
    repeat (3) step(0, 1, 1);
    repeat (3) step(0, 1, 0);
    drain(20);

    // Three strobes while stalled: third is dropped
    fill_random(); step(1, 0, 1);
    fill_random(); step(1, 0, 1);
    fill_random(); step(1, 0, 1);
    check("drop_after_3", drop_cnt, 1);
    check("overrun_after_3", overrun, 1);
    drain(40);

    // Strobe on final handshake, pending empty
    fill_random(); step(1, 1, 1);
    for (int i = 0; i < 20 && q.size() > 1; i++) step(0, 1, 1);
    fill_random(); step(1, 1, 1);
    drain(40);

    // Strobe on final handshake, pending full
    fill_random(); step(1, 0, 1);
    fill_random(); step(1, 0, 1);
    for (int i = 0; i < 20 && q.size() > 17; i++) step(0, 1, 1);
    fill_random(); step(1, 1, 1);
    check("no_drop_on_final", drop_cnt, 1);
    drain(60);

    // Reset mid-frame at channel 7
    fill_random(); step(1, 1, 1);
    for (int i = 0; i < 20 && q.size() > 0 && q[0].c != 4'd7; i++) step(0, 1, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ch", out_ch, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_sat", out_sat, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_busy", busy, 0);
    q.delete();
    exp_drops = 0;
    @(posedge clock); #2;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    repeat (5) step(0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit stb;
      stb = ($urandom_range(0, 5) == 0);
      if (stb) fill_random();
      step(stb, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    end
    drain(200);
    check("final_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
